pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised program-counter unit for the transputer datapath; successor to the fixed +1 PC adder.
//   Holds the PC register and advances it by STEP each cycle. Supports stall, relative branch,
//   absolute jump, and call/return through an internal return-address stack of DEPTH entries.
//   Sits between the control unit (event strobes) and instruction memory (address = pc).
// PARAMETERS
//   WIDTH     16   PC / address width in bits
//   STEP      1    increment applied on sequential advance (unsigned, < 2**WIDTH)
//   OFF_W     8    branch offset width, two's complement, sign-extended to WIDTH
//   DEPTH     4    return-address stack entries (>=1)
//   RESET_PC  0    PC value loaded on reset
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   stall       in   1        hold PC and stack this cycle
//   jump        in   1        load PC from jump_addr
//   jump_addr   in   WIDTH    absolute jump target
//   branch      in   1        PC <= PC + sext(branch_off)
//   branch_off  in   OFF_W    signed branch offset
//   call        in   1        push PC+STEP, PC <= jump_addr
//   ret         in   1        pop stack top into PC
//   clr_err     in   1        clear sticky ovf/unf flags
//   pc          out  WIDTH    current PC (registered)
//   next_pc     out  WIDTH    combinational value PC takes at next edge
//   sp          out  clog2(DEPTH+1)  number of valid stack entries
//   ovf         out  1        sticky: call attempted with stack full
//   unf         out  1        sticky: ret attempted with stack empty
// BEHAVIOUR
//   - Reset (rst_n=0, async): pc=RESET_PC, sp=0, ovf=0, unf=0, stack contents don't-care.
//   - Priority per cycle: stall > ret > call > jump > branch > sequential (PC+STEP).
//   - stall=1: pc, sp, stack unchanged; next_pc=pc; other strobes ignored, no flag updates.
//   - ret, sp>0: pc <= stack[sp-1]; sp <= sp-1.
//   - ret, sp==0: pc <= pc+STEP; sp stays 0; unf <= 1.
//   - call, sp<DEPTH: stack[sp] <= pc+STEP; sp <= sp+1; pc <= jump_addr.
//   - call, sp==DEPTH: pc <= jump_addr; no push, stack intact; ovf <= 1.
//   - jump: pc <= jump_addr. branch: pc <= pc + sext(branch_off).
//   - All arithmetic modulo 2**WIDTH; wrap from max to 0 (or below 0 to max) is silent, not an error.
//   - Latency: strobes sampled at edge N, new pc visible after edge N; next_pc shows it before edge.
//   - clr_err clears ovf/unf at the edge; a same-cycle ovf/unf event wins (flag set).
//   - Reset mid-call/ret: state returns to reset values immediately; no partial push survives.
// TESTING (WIDTH=16, STEP=1, OFF_W=8, DEPTH=4, RESET_PC=0)
//   1. Release reset, 5 idle cycles -> pc 0,1,2,3,4,5; assert stall 2 cycles -> pc holds 5; next_pc=5.
//   2. pc=0x0010, branch_off=8'hFC -> pc=0x000C; pc=0xFFFF sequential -> pc=0x0000, no flags.
//   3. pc=0x0020, call jump_addr=0x0100 -> pc=0x0100, sp=1; ret -> pc=0x0021, sp=0.
//   4. Five nested calls from pc=0x10,0x20,..: 5th sets ovf, sp stays 4; four rets return 0x41,0x31,0x21,0x11.
//   5. ret with sp=0 at pc=0x0050 -> pc=0x0051, unf=1; clr_err -> unf=0; ret+call+jump same cycle -> ret wins.
//   6. Assert rst_n low mid-cycle with sp=3 -> pc=0, sp=0 at once without clock; flags 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter unit: sequential advance, stall, relative branch, absolute jump,
// and call/return through a small internal return-address stack with sticky error flags.
module pc_sequencer #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      STEP     = 1,
  parameter int unsigned      OFF_W    = 8,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         jump,
  input  logic [WIDTH-1:0]             jump_addr,
  input  logic                         branch,
  input  logic [OFF_W-1:0]             branch_off,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             next_pc,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         ovf,
  output logic                         unf
);

  localparam int unsigned      SP_W    = $clog2(DEPTH + 1);
  localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] br_pc;
  logic [WIDTH-1:0] off_ext;
  logic [SP_W-1:0]  sp_dec;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             unf_set;
  logic             clr;

  // Wrap-around is intentional: all PC arithmetic is modulo 2**WIDTH.
  assign seq_pc   = pc + STEP_V;
  assign off_ext  = WIDTH'($signed(branch_off));
  assign br_pc    = pc + off_ext;
  assign sp_dec   = sp - SP_ONE;
  assign top_idx  = IDX_W'(sp_dec);
  assign push_idx = IDX_W'(sp);
  assign clr      = clr_err & ~stall;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    next_pc = seq_pc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (stall) begin
      next_pc = pc;
    end else if (ret) begin
      if (sp != '0) begin
        next_pc = stack[top_idx];
        pop     = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (call) begin
      next_pc = jump_addr;
      if (sp != SP_FULL) push = 1'b1;
      else               ovf_set = 1'b1;
    end else if (jump) begin
      next_pc = jump_addr;
    end else if (branch) begin
      next_pc = br_pc;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      pc <= next_pc;
      if (push)     sp <= sp + SP_ONE;
      else if (pop) sp <= sp - SP_ONE;
      // A same-cycle error event beats the clear.
      ovf <= ovf_set | (ovf & ~clr);
      unf <= unf_set | (unf & ~clr);
    end
  end

  // NOTE: stack storage is deliberately not reset; sp=0 marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= seq_pc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal expectations,
// then randomized strobes compared every cycle against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int WIDTH = 16;
  localparam int STEP  = 1;
  localparam int OFF_W = 8;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0;
  logic              jump = 1'b0;
  logic              branch = 1'b0;
  logic              call = 1'b0;
  logic              ret = 1'b0;
  logic              clr_err = 1'b0;
  logic [WIDTH-1:0]  jump_addr = '0;
  logic [OFF_W-1:0]  branch_off = '0;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  next_pc;
  logic [2:0]        sp;
  logic              ovf;
  logic              unf;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: the stack is a plain queue, the PC a plain integer.
  int m_pc;
  int m_stack[$];
  bit m_ovf;
  bit m_unf;
  int n_pc;
  bit n_ovf;
  bit n_unf;
  int n_op;   // 0 = no stack change, 1 = push, 2 = pop

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH(WIDTH), .STEP(STEP), .OFF_W(OFF_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .jump_addr(jump_addr),
    .branch(branch), .branch_off(branch_off), .call(call), .ret(ret), .clr_err(clr_err),
    .pc(pc), .next_pc(next_pc), .sp(sp), .ovf(ovf), .unf(unf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_predict();
    n_op  = 0;
    n_pc  = m_pc;
    n_ovf = m_ovf;
    n_unf = m_unf;
    if (stall) return;
    if (clr_err) begin
      n_ovf = 1'b0;
      n_unf = 1'b0;
    end
    if (ret) begin
      if (m_stack.size() > 0) begin
        n_pc = m_stack[$];
        n_op = 2;
      end else begin
        n_pc  = (m_pc + STEP) % MOD;
        n_unf = 1'b1;
      end
    end else if (call) begin
      n_pc = int'(jump_addr);
      if (m_stack.size() < DEPTH) n_op = 1;
      else                        n_ovf = 1'b1;
    end else if (jump) begin
      n_pc = int'(jump_addr);
    end else if (branch) begin
      int off;
      off  = (int'(branch_off) >= 128) ? int'(branch_off) - 256 : int'(branch_off);
      n_pc = (m_pc + off + MOD) % MOD;
    end else begin
      n_pc = (m_pc + STEP) % MOD;
    end
  endtask

  task automatic model_commit();
    if (n_op == 1) m_stack.push_back((m_pc + STEP) % MOD);
    if (n_op == 2) void'(m_stack.pop_back());
    m_pc  = n_pc;
    m_ovf = n_ovf;
    m_unf = n_unf;
  endtask

  // One clock cycle: drive strobes at the falling edge, compare everything, advance the model.
  task automatic cycle(input logic st, input logic rt, input logic cl, input logic jp,
                       input logic br, input logic [15:0] ja, input logic [7:0] bo,
                       input logic ce);
    @(negedge clk);
    stall = st; ret = rt; call = cl; jump = jp; branch = br;
    jump_addr = ja; branch_off = bo; clr_err = ce;
    #1;
    model_predict();
    check("pc", pc, m_pc);
    check("sp", sp, m_stack.size());
    check("ovf", ovf, m_ovf);
    check("unf", unf, m_unf);
    check("next_pc", next_pc, n_pc);
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 16'h0000, 8'h00, 0);
  endtask

  task automatic do_jump(input logic [15:0] a);
    cycle(0, 0, 0, 1, 0, a, 8'h00, 0);
  endtask

  task automatic do_call(input logic [15:0] a);
    cycle(0, 0, 1, 0, 0, a, 8'h00, 0);
  endtask

  task automatic do_ret();
    cycle(0, 1, 0, 0, 0, 16'h0000, 8'h00, 0);
  endtask

  initial begin
    int exp_ret[4] = '{32'h41, 32'h31, 32'h21, 32'h11};
    model_reset();

    // Reset state, then release between edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 0);
    check("rst_sp", sp, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    rst_n = 1'b1;

    // Idle counting and stall hold.
    repeat (5) idle();
    check("t1_pc5", pc, 16'h0005);
    cycle(1, 0, 0, 0, 0, 16'h0000, 8'h00, 0);
    cycle(1, 1, 1, 1, 1, 16'h1234, 8'h10, 1);
    check("t1_stall_pc", pc, 16'h0005);
    check("t1_stall_next", next_pc, 16'h0005);

    // Negative branch and silent wrap.
    do_jump(16'h0010);
    cycle(0, 0, 0, 0, 1, 16'h0000, 8'hFC, 0);
    check("t2_branch", pc, 16'h000C);
    do_jump(16'hFFFF);
    idle();
    check("t2_wrap", pc, 16'h0000);
    check("t2_wrap_ovf", ovf, 0);
    check("t2_wrap_unf", unf, 0);

    // Single call/return.
    do_jump(16'h0020);
    do_call(16'h0100);
    check("t3_call_pc", pc, 16'h0100);
    check("t3_call_sp", sp, 1);
    do_ret();
    check("t3_ret_pc", pc, 16'h0021);
    check("t3_ret_sp", sp, 0);

    // Nested calls overflow the stack; returns unwind in LIFO order.
    do_jump(16'h0010);
    for (int k = 2; k <= 6; k++) do_call(16'(k * 16));
    check("t4_pc", pc, 16'h0060);
    check("t4_sp", sp, 4);
    check("t4_ovf", ovf, 1);
    for (int k = 0; k < 4; k++) begin
      do_ret();
      check("t4_ret", pc, exp_ret[k]);
    end
    cycle(0, 0, 0, 0, 0, 16'h0000, 8'h00, 1);
    check("t4_clr_ovf", ovf, 0);

    // Underflow, clear, clear losing to a same-cycle event, and ret priority.
    do_jump(16'h0050);
    do_ret();
    check("t5_unf_pc", pc, 16'h0051);
    check("t5_unf", unf, 1);
    cycle(0, 0, 0, 0, 0, 16'h0000, 8'h00, 1);
    check("t5_clr_unf", unf, 0);
    cycle(0, 1, 0, 0, 0, 16'h0000, 8'h00, 1);
    check("t5_set_wins", unf, 1);
    do_call(16'h0200);
    cycle(0, 1, 1, 1, 1, 16'h0300, 8'h05, 0);
    check("t5_prio_pc", pc, 16'h0054);
    check("t5_prio_sp", sp, 0);
    check("t5_prio_ovf", ovf, 0);

    // Asynchronous reset in the middle of a cycle with a populated stack.
    for (int k = 0; k < 3; k++) do_call(16'(16'h0400 + k * 16));
    check("t6_sp3", sp, 3);
    @(negedge clk);
    stall = 0; ret = 0; call = 1; jump = 0; branch = 0; clr_err = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_pc", pc, 0);
    check("t6_sp", sp, 0);
    check("t6_ovf", ovf, 0);
    check("t6_unf", unf, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized strobes against the model.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ja;
      ja = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3))
                                       : 16'($urandom_range(0, 65535));
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 3) == 0, ja, 8'($urandom_range(0, 255)),
            $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
